// File: rtl/edge_event_ctrl.sv
// Per-channel edge detector feeding sticky pending/overflow bits, with a
// round-robin arbiter presenting unmasked pending channels on a valid/ready port.
module edge_event_ctrl #(
  parameter int DW   = 32,
  parameter int SYNC = 1,
  parameter int IDW  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DW-1:0]   in,
  input  logic [2*DW-1:0] mode,
  input  logic [DW-1:0]   mask,
  input  logic [DW-1:0]   clr,
  output logic            evt_valid,
  output logic [IDW-1:0]  evt_id,
  input  logic            evt_ready,
  output logic [DW-1:0]   pending,
  output logic [DW-1:0]   overflow,
  output logic            irq
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t         state;
  logic [DW-1:0]  s1;
  logic [DW-1:0]  s1_next;
  logic [DW-1:0]  prev;
  logic           warm;
  logic           primed;
  logic [DW-1:0]  rise;
  logic [DW-1:0]  fall;
  logic [DW-1:0]  sel;
  logic [DW-1:0]  edge_hit;
  logic [DW-1:0]  accept_vec;
  logic [DW-1:0]  req;
  logic [DW-1:0]  pending_next;
  logic [DW-1:0]  overflow_next;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] pick_id;
  logic           pick_found;

  generate
    if (SYNC != 0) begin : g_sync
      logic [DW-1:0] s0;
      // First synchronizer stage for asynchronous input lines.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s0 <= '0;
        end else begin
          s0 <= in;
        end
      end
      assign s1_next = s0;
    end else begin : g_direct
      assign s1_next = in;
    end
  endgenerate

  // Sample register and previous value. Until primed, prev shadows the value
  // entering s1 so that lines held high through reset do not look like edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= '0;
      prev   <= '0;
      warm   <= 1'b0;
      primed <= 1'b0;
    end else begin
      s1     <= s1_next;
      prev   <= primed ? s1 : s1_next;
      warm   <= 1'b1;
      primed <= (SYNC == 0) ? 1'b1 : warm;
    end
  end

  // Per-channel edge selection from the two-bit mode field.
  always_comb begin
    rise = s1 & ~prev;
    fall = ~s1 & prev;
    sel  = '0;
    for (int i = 0; i < DW; i++) begin
      case (mode[2*i +: 2])
        2'b01:   sel[i] = rise[i];
        2'b10:   sel[i] = fall[i];
        2'b11:   sel[i] = rise[i] | fall[i];
        default: sel[i] = 1'b0;
      endcase
    end
    edge_hit = sel & {DW{primed}};
  end

  // Next-state of pending and overflow: a fresh edge beats accept/clr, and a
  // same-cycle accept or clr keeps that edge from counting as an overflow.
  always_comb begin
    accept_vec = '0;
    for (int i = 0; i < DW; i++) begin
      accept_vec[i] = evt_valid & evt_ready & (evt_id == IDW'(i));
    end
    req           = pending & ~mask;
    pending_next  = edge_hit | (pending & ~(accept_vec | clr));
    overflow_next = (overflow | (edge_hit & pending & ~accept_vec)) & ~clr;
  end

  // Round-robin pick: channels at or above rr_ptr first, then wrap to the low ones.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = 0; i < DW; i++) begin
      if (!pick_found && req[i] && (IDW'(i) >= rr_ptr)) begin
        pick_found = 1'b1;
        pick_id    = IDW'(i);
      end else begin
        pick_found = pick_found;
      end
    end
    for (int i = 0; i < DW; i++) begin
      if (!pick_found && req[i]) begin
        pick_found = 1'b1;
        pick_id    = IDW'(i);
      end else begin
        pick_found = pick_found;
      end
    end
  end

  // Sticky status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      overflow <= '0;
    end else begin
      pending  <= pending_next;
      overflow <= overflow_next;
    end
  end

  // Arbiter FSM: the presented id is held until accepted, never retracted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            evt_id    <= pick_id;
            evt_valid <= 1'b1;
            state     <= ST_PRESENT;
          end else begin
            evt_valid <= 1'b0;
          end
        end
        ST_PRESENT: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            state     <= ST_IDLE;
            if (evt_id == IDW'(DW-1)) begin
              rr_ptr <= '0;
            end else begin
              rr_ptr <= evt_id + IDW'(1'b1);
            end
          end else begin
            evt_valid <= 1'b1;
          end
        end
        default: begin
          evt_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign irq = |req;

endmodule

// File: tb/tb_edge_event_ctrl.sv
// Directed bench for edge_event_ctrl: SYNC=0 instance for the main checks plus a
// SYNC=1 instance for synchronizer latency and asynchronous reset of evt_valid.
module tb_edge_event_ctrl;

  localparam int DW  = 32;
  localparam int IDW = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [DW-1:0]   in;
  logic [2*DW-1:0] mode;
  logic [DW-1:0]   mask;
  logic [DW-1:0]   clr;
  logic            evt_ready;

  logic            evt_valid,  evt_valid_s;
  logic [IDW-1:0]  evt_id,     evt_id_s;
  logic [DW-1:0]   pending,    pending_s;
  logic [DW-1:0]   overflow,   overflow_s;
  logic            irq,        irq_s;

  int errors = 0;
  int checks = 0;
  int exp_ids_a[3] = '{0, 5, 9};
  int exp_ids_b[2] = '{0, 9};

  always #5 clk = ~clk;

  edge_event_ctrl #(.DW(DW), .SYNC(0), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .in(in), .mode(mode), .mask(mask), .clr(clr),
    .evt_valid(evt_valid), .evt_id(evt_id), .evt_ready(evt_ready),
    .pending(pending), .overflow(overflow), .irq(irq)
  );

  edge_event_ctrl #(.DW(DW), .SYNC(1), .IDW(IDW)) dut_s (
    .clk(clk), .reset(reset), .in(in), .mode(mode), .mask(mask), .clr(clr),
    .evt_valid(evt_valid_s), .evt_id(evt_id_s), .evt_ready(evt_ready),
    .pending(pending_s), .overflow(overflow_s), .irq(irq_s)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [2*DW-1:0] mode_one(input int ch, input logic [1:0] m);
    logic [2*DW-1:0] v;
    v = '0;
    v[2*ch +: 2] = m;
    return v;
  endfunction

  initial begin
    reset = 1'b1; in = '1; mode = '1; mask = '0; clr = '0; evt_ready = 1'b0;
    tick(3);
    check_eq("rst pending", pending, 0);
    check_eq("rst valid", evt_valid, 0);
    check_eq("rst irq", irq, 0);
    reset = 1'b0;
    tick(4);
    check_eq("prime pending", pending, 0);
    check_eq("prime overflow", overflow, 0);
    check_eq("prime valid", evt_valid, 0);
    check_eq("prime pending sync", pending_s, 0);

    // Single rising edge on ch3.
    mode = '0; in = '0;
    tick(3);
    check_eq("mode off pending", pending, 0);
    mode = mode_one(3, 2'b01);
    in[3] = 1'b1;
    tick(1);
    check_eq("ch3 k pending", pending, 0);
    tick(1);
    check_eq("ch3 k1 pending", pending, 32'h8);
    check_eq("ch3 k1 irq", irq, 1);
    check_eq("ch3 k1 valid", evt_valid, 0);
    check_eq("ch3 k1 pending sync", pending_s, 0);
    tick(1);
    check_eq("ch3 k2 valid", evt_valid, 1);
    check_eq("ch3 k2 id", evt_id, 3);
    check_eq("ch3 k2 pending sync", pending_s, 32'h8);
    evt_ready = 1'b1;
    tick(1);
    check_eq("ch3 k3 pending", pending, 0);
    check_eq("ch3 k3 valid", evt_valid, 0);
    evt_ready = 1'b0;
    tick(1);
    check_eq("sync valid held", evt_valid_s, 1);
    check_eq("sync id held", evt_id_s, 3);

    // Asynchronous reset while the SYNC=1 instance is presenting.
    in = '0; mode = '0;
    reset = 1'b1;
    #1;
    check_eq("async rst valid", evt_valid_s, 0);
    tick(2);
    reset = 1'b0;
    tick(3);

    // Simultaneous edges on ch0/5/9, ready held high.
    mode = mode_one(0, 2'b11) | mode_one(5, 2'b11) | mode_one(9, 2'b11);
    evt_ready = 1'b1;
    in = 32'h221;
    tick(2);
    check_eq("rr pending", pending, 32'h221);
    for (int j = 0; j < 3; j++) begin
      tick(1);
      check_eq($sformatf("rr a valid %0d", j), evt_valid, 1);
      check_eq($sformatf("rr a id %0d", j), evt_id, exp_ids_a[j]);
      tick(1);
      check_eq($sformatf("rr a bubble %0d", j), evt_valid, 0);
    end
    check_eq("rr a drained", pending, 0);
    // Falling edges on ch0 and ch9; pointer sits at 10, so the search wraps to 0 first.
    in = 32'h020;
    tick(2);
    check_eq("rr b pending", pending, 32'h201);
    for (int j = 0; j < 2; j++) begin
      tick(1);
      check_eq($sformatf("rr b valid %0d", j), evt_valid, 1);
      check_eq($sformatf("rr b id %0d", j), evt_id, exp_ids_b[j]);
      tick(1);
      check_eq($sformatf("rr b bubble %0d", j), evt_valid, 0);
    end
    check_eq("rr b drained", pending, 0);
    evt_ready = 1'b0;

    // Overflow and clear on masked ch2 (falling mode).
    mode = mode_one(2, 2'b10);
    mask = 32'h4;
    in[2] = 1'b1; tick(2); in[2] = 1'b0; tick(2);
    check_eq("ch2 pending", pending, 32'h4);
    check_eq("ch2 no ovf", overflow, 0);
    check_eq("ch2 masked irq", irq, 0);
    in[2] = 1'b1; tick(2); in[2] = 1'b0; tick(2);
    check_eq("ch2 ovf", overflow, 32'h4);
    check_eq("ch2 ovf pending", pending, 32'h4);
    clr = 32'h4; tick(1); clr = '0;
    check_eq("ch2 clr pending", pending, 0);
    check_eq("ch2 clr ovf", overflow, 0);
    in[2] = 1'b1; tick(2); in[2] = 1'b0; tick(1);
    clr = 32'h4; tick(1); clr = '0;
    check_eq("ch2 edge+clr pending", pending, 32'h4);
    check_eq("ch2 edge+clr ovf", overflow, 0);
    in[2] = 1'b1; tick(2); in[2] = 1'b0; tick(1);
    clr = 32'h4; tick(1); clr = '0;
    check_eq("ch2 clr wins pending", pending, 32'h4);
    check_eq("ch2 clr wins ovf", overflow, 0);
    clr = 32'h4; tick(1); clr = '0;
    mask = '0;
    check_eq("ch2 final pending", pending, 0);

    // Masked ch7 latches but is not granted until unmasked.
    mode = mode_one(7, 2'b01);
    mask = 32'h80;
    in[7] = 1'b1;
    tick(2);
    check_eq("ch7 pending", pending, 32'h80);
    check_eq("ch7 masked irq", irq, 0);
    tick(1);
    check_eq("ch7 masked valid", evt_valid, 0);
    mask = '0;
    #1;
    check_eq("ch7 unmask irq", irq, 1);
    tick(1);
    check_eq("ch7 valid", evt_valid, 1);
    check_eq("ch7 id", evt_id, 7);
    mask = 32'h80;
    tick(2);
    check_eq("ch7 hold valid", evt_valid, 1);
    check_eq("ch7 hold id", evt_id, 7);
    mask = '0;
    evt_ready = 1'b1;
    tick(1);
    check_eq("ch7 accepted pending", pending, 0);
    check_eq("ch7 accepted valid", evt_valid, 0);
    evt_ready = 1'b0;

    // Edge on ch4 in the same cycle ch4 is accepted.
    mode = mode_one(4, 2'b11);
    in[4] = 1'b1;
    tick(3);
    check_eq("ch4 valid", evt_valid, 1);
    check_eq("ch4 id", evt_id, 4);
    in[4] = 1'b0;
    tick(1);
    check_eq("ch4 still valid", evt_valid, 1);
    evt_ready = 1'b1;
    tick(1);
    check_eq("ch4 accept+edge pending", pending, 32'h10);
    check_eq("ch4 accept+edge ovf", overflow, 0);
    check_eq("ch4 bubble", evt_valid, 0);
    tick(1);
    check_eq("ch4 re-presented", evt_valid, 1);
    check_eq("ch4 re id", evt_id, 4);
    tick(1);
    check_eq("ch4 done pending", pending, 0);
    check_eq("ch4 done valid", evt_valid, 0);
    evt_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
